// File: rtl/maxnet_sequencer.sv
// Sequences five operand words into the Maxnet core, pulses start, waits for
// finish (or a timeout) and hands the captured winner downstream.
module maxnet_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] mx_epsilon,
  output logic [WIDTH-1:0] mx_a1,
  output logic [WIDTH-1:0] mx_a2,
  output logic [WIDTH-1:0] mx_a3,
  output logic [WIDTH-1:0] mx_a4,
  output logic             mx_start,
  input  logic             mx_finish,
  input  logic [WIDTH-1:0] mx_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_timeout
);

  localparam int         NUM_OPS = 5;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;

  state_t                           state, state_nxt;
  logic [2:0]                       wcnt;
  logic [15:0]                      cyc;
  logic [NUM_OPS-1:0][WIDTH-1:0]    opnd;
  logic                             xfer, fin_hit, to_hit;

  assign mx_epsilon = opnd[0];
  assign mx_a1      = opnd[1];
  assign mx_a2      = opnd[2];
  assign mx_a3      = opnd[3];
  assign mx_a4      = opnd[4];

  assign in_ready  = (state == LOAD);
  assign mx_start  = (state == START);
  assign res_valid = (state == RESULT);
  assign xfer      = in_valid && in_ready;

  // The first WAIT cycle may still see finish left high by the previous run.
  assign fin_hit = (state == WAIT) && (cyc != 16'd0) && mx_finish;
  assign to_hit  = (state == WAIT) && (cyc == TO_LAST) && !fin_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (xfer && wcnt == 3'd4) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (fin_hit || to_hit) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
      opnd <= '0;
    end else if (xfer) begin
      wcnt <= (wcnt == 3'd4) ? 3'd0 : wcnt + 3'd1;
      for (int k = 0; k < NUM_OPS; k++)
        if (wcnt == 3'(k)) opnd[k] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cyc <= '0;
    else if (state == START) cyc <= '0;
    else if (state == WAIT)  cyc <= cyc + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data    <= '0;
      res_timeout <= 1'b0;
    end else if (fin_hit) begin
      res_data    <= mx_out;
      res_timeout <= 1'b0;
    end else if (to_hit) begin
      res_data    <= '0;
      res_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Randomized bench: a cycle-level core model answers each start pulse after a
// chosen delay; expected result timing/value comes from the sequencing rules.
module tb_maxnet_sequencer;
  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4;
  logic         mx_start;
  logic         mx_finish = 1'b0;
  logic [W-1:0] mx_out = '0;
  logic         res_valid, res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_timeout;

  logic [4:0][W-1:0] ops;
  assign ops = {mx_a4, mx_a3, mx_a2, mx_a1, mx_epsilon};

  int n_tests = 0;
  int n_fail  = 0;

  maxnet_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mx_epsilon(mx_epsilon), .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3), .mx_a4(mx_a4),
    .mx_start(mx_start), .mx_finish(mx_finish), .mx_out(mx_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full job: load w (eps..a4), core raises finish from WAIT cycle 1+d on,
  // stale keeps the previous finish level high through LOAD/START/first WAIT.
  task automatic run_job(input logic [4:0][W-1:0] w, input bit gap, input int d,
                         input bit stale, input int hold);
    int k = 0, cyc = 0, r, first;
    logic [W-1:0] win, old, exp_data;
    logic exp_to;
    win = w[1];
    for (int i = 2; i < 5; i++) if (w[i] > win) win = w[i];
    old = ~win;
    while (k < 5 && cyc < 40) begin
      chk("in_ready_load", in_ready, 1);
      chk("no_start_load", mx_start, 0);
      chk("no_res_load", res_valid, 0);
      in_valid  = !gap || (cyc % 2 == 0);
      in_data   = in_valid ? w[k] : $urandom;
      res_ready = 1'($urandom);
      mx_finish = stale;
      mx_out    = old;
      tick();
      if (in_valid) k++;
      cyc++;
    end
    if (k < 5) begin
      chk("load_budget", k, 5);
      return;
    end
    chk("start_pulse", mx_start, 1);
    chk("in_ready_start", in_ready, 0);
    chk("ops_loaded", ops, w);
    in_valid = 1'($urandom); in_data = $urandom; res_ready = 1'($urandom);
    // finish is only honoured on WAIT cycles 2..TO; otherwise timeout after TO
    first = (1 + d > 2) ? 1 + d : 2;
    if (first <= TO) begin r = first + 1; exp_data = win; exp_to = 1'b0; end
    else             begin r = TO + 1;    exp_data = '0;  exp_to = 1'b1; end
    for (int c = 1; c < r; c++) begin
      tick();
      chk("wait_no_valid", res_valid, 0);
      chk("wait_no_start", mx_start, 0);
      chk("wait_in_ready", in_ready, 0);
      chk("ops_stable", ops, w);
      mx_finish = (stale && c == 1) || (c >= 1 + d);
      mx_out    = (c >= 1 + d) ? win : old;
      in_valid  = 1'($urandom); in_data = $urandom; res_ready = 1'($urandom);
    end
    tick();
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) tick();
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, exp_data);
      chk("res_timeout", res_timeout, exp_to);
      chk("res_in_ready", in_ready, 0);
      chk("res_ops", ops, w);
      res_ready = (h == hold);
      in_valid  = 1'b1;
      in_data   = $urandom;
    end
    tick();
    in_valid  = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_start"}, mx_start, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_to"}, res_timeout, 0);
    chk({tag, "_ops"}, ops, 0);
  endtask

  // Feed nwords, idle `extra` cycles, then pulse reset across one edge.
  task automatic abort_job(input int nwords, input int extra);
    for (int k = 0; k < nwords; k++) begin
      in_valid = 1'b1; in_data = $urandom | 32'h1; mx_finish = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    for (int e = 0; e < extra; e++) tick();
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    tick();
    chk("rst_held_start", mx_start, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [4:0][W-1:0] w;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    w = {32'h05, 32'h20, 32'h40, 32'h10, 32'h02};
    run_job(w, 1'b0, 6, 1'b0, 0);
    run_job(w, 1'b1, 6, 1'b0, 0);
    run_job(w, 1'b0, 20, 1'b0, 0);         // finish never: timeout
    run_job(w, 1'b0, 2, 1'b0, 0);          // leaves finish high for the next job
    run_job(w, 1'b0, 1, 1'b1, 0);          // stale finish in first WAIT cycle
    run_job(w, 1'b0, TO - 1, 1'b0, 0);     // finish on the timeout cycle wins
    run_job(w, 1'b0, TO, 1'b0, 0);         // one cycle too late
    run_job(w, 1'b0, 0, 1'b0, 10);         // downstream stalls 10 cycles

    abort_job(5, 2);                       // reset in WAIT
    w = {32'h11, 32'h77, 32'h33, 32'h55, 32'h09};
    run_job(w, 1'b0, 3, 1'b0, 0);
    abort_job(2, 0);                       // reset mid-load
    run_job(w, 1'b1, 4, 1'b0, 1);

    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 5; i++) w[i] = $urandom;
      run_job(w, 1'($urandom), int'($urandom_range(0, 10)), 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/maxnet_sequencer.md
MAXNET_SEQUENCER -- requirements
Module: maxnet_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter TIMEOUT, default 1024, max cycles to wait for mx_finish.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port in_ready, output, 1, sequencer accepts a word.
REQ-007 SHALL have port in_data, input, WIDTH, upstream word.
REQ-008 SHALL have ports mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4, output, WIDTH each, operands to Maxnet core.
REQ-009 SHALL have port mx_start, output, 1, one-cycle start pulse to Maxnet core.
REQ-010 SHALL have port mx_finish, input, 1, Maxnet core done level.
REQ-011 SHALL have port mx_out, input, WIDTH, Maxnet core winner value.
REQ-012 SHALL have port res_valid, output, 1, result available.
REQ-013 SHALL have port res_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port res_data, output, WIDTH, captured winner value.
REQ-015 SHALL have port res_timeout, output, 1, qualifies res_data as invalid due to timeout.

Function
REQ-016 SHALL implement FSM states LOAD, START, WAIT, RESULT; reset state LOAD.
REQ-017 LOAD: in_ready=1; transfer when in_valid&in_ready; 3-bit word counter 0..4.
REQ-018 Word order SHALL be epsilon, a1, a2, a3, a4; word k is written to its register on transfer k.
REQ-019 On transfer of word 4, counter SHALL clear to 0 and FSM SHALL go to START next cycle.
REQ-020 in_ready SHALL be 0 in START, WAIT, RESULT; in_valid there SHALL be ignored.
REQ-021 START: mx_start=1 for exactly one cycle, then WAIT.
REQ-022 mx_epsilon, mx_a1..mx_a4 SHALL stay stable from end of LOAD until the next LOAD transfer updates them.
REQ-023 WAIT: mx_finish SHALL be ignored in the first WAIT cycle (stale level from previous run); sampled from the second WAIT cycle on.
REQ-024 WAIT: 16-bit cycle counter cleared on entry, increments each WAIT cycle.
REQ-025 Sampled mx_finish=1: res_data<=mx_out, res_timeout<=0, go to RESULT.
REQ-026 Counter reaching TIMEOUT-1 with mx_finish=0: res_data<=0, res_timeout<=1, go to RESULT.
REQ-027 mx_finish and timeout in the same cycle: finish SHALL win.
REQ-028 RESULT: res_valid=1; res_data/res_timeout stable until res_valid&res_ready, then LOAD next cycle.
REQ-029 res_valid SHALL not depend combinationally on res_ready; res_ready while not in RESULT ignored.
REQ-030 Minimum latency, word-4 transfer to res_valid: 4 cycles (START, 2 WAIT, RESULT) given mx_finish already high.
REQ-031 Back-to-back jobs: first new word accepted the cycle after result handshake.

Reset
REQ-032 On rst=0, asynchronously: FSM=LOAD, counters=0, operand registers=0, res_data=0, res_timeout=0, res_valid=0, mx_start=0, in_ready=1 after release.
REQ-033 Reset mid-job (any state) SHALL discard partial load and pending result; mx_start SHALL not be emitted.
REQ-034 First transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-035 Load 0x2, 0x10, 0x40, 0x20, 0x05 continuous; model raises mx_finish after 6 cycles with mx_out=0x40 -> one mx_start pulse, mx_a2=0x40, res_data=0x40, res_timeout=0.
REQ-036 Same words with in_valid gapped every other cycle -> identical operands and result; no extra mx_start.
REQ-037 mx_finish tied low, TIMEOUT=8 -> res_valid after 8 WAIT cycles, res_timeout=1, res_data=0.
REQ-038 mx_finish held high from prior job -> not sampled in first WAIT cycle; result captured on second.
REQ-039 res_ready held low 10 cycles in RESULT -> res_valid/res_data stable, in_ready=0, in_valid words dropped.
REQ-040 rst pulsed low in WAIT -> outputs at reset values immediately; next 5 words start a fresh job correctly.
